univ_reg: RTL and testbench



---
 rtl/univ_reg_pkg.sv | 22 ++
 rtl/univ_reg_alu.sv | 103 ++++++++++
 rtl/univ_reg.sv | 70 +++++++
 tb/tb_univ_reg.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/univ_reg_pkg.sv
// -----------------------------------------------------------------------------
// univ_reg_pkg
// Shared definitions for the universal register block.
//   UNIV_REG_OP_W : width of the opcode field (3 bits, eight operations)
//   op_e          : opcode encoding OP_NOP .. OP_CLR
// -----------------------------------------------------------------------------
package univ_reg_pkg;

   localparam int UNIV_REG_OP_W = 3;

   typedef enum logic [UNIV_REG_OP_W-1:0] {
      OP_NOP = 3'd0,
      OP_LD  = 3'd1,
      OP_INC = 3'd2,
      OP_DEC = 3'd3,
      OP_SHL = 3'd4,
      OP_SHR = 3'd5,
      OP_ROL = 3'd6,
      OP_CLR = 3'd7
   } op_e;

endpackage

// File: rtl/univ_reg_alu.sv
// -----------------------------------------------------------------------------
// univ_reg_alu
// Purely combinational next-state logic for univ_reg. Given the current
// register value and an opcode it produces the next register value and the
// next carry/borrow/shift-out flag.
// Configuration macro: UNIV_REG_SAT_EN (when defined, INC/DEC saturate at
// all-ones / zero instead of wrapping; cf still reports the overflow).
// Ports:
//   cur    in   WIDTH  current register contents
//   in     in   WIDTH  parallel load data
//   sin    in   1      serial input for SHL/SHR
//   op     in   3      operation select
//   nxt    out  WIDTH  next register contents
//   nxt_cf out  1      next carry/borrow/shift-out flag
// For OP_NOP the outputs are don't-care; the top never loads them.
// -----------------------------------------------------------------------------
module univ_reg_alu
   import univ_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]         cur,
   input  logic [WIDTH-1:0]         in,
   input  logic                     sin,
   input  logic [UNIV_REG_OP_W-1:0] op,
   output logic [WIDTH-1:0]         nxt,
   output logic                     nxt_cf
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

`ifndef UNIV_REG_SAT_EN
   // One extra bit on the increment so the carry falls out of the sum.
   logic [WIDTH:0] inc_sum;
   assign inc_sum = {1'b0, cur} + {1'b0, ONE};
`endif

   // Decode the opcode into the next value and flag. Shifts and rotate
   // report the bit pushed out of the top (left) or bottom (right).
   always_comb begin
      nxt    = cur;
      nxt_cf = 1'b0;
      case (op_e'(op))
         OP_NOP: begin
            nxt    = cur;
            nxt_cf = 1'b0;
         end
         OP_LD: begin
            nxt    = in;
            nxt_cf = 1'b0;
         end
         OP_INC: begin
`ifdef UNIV_REG_SAT_EN
            if (&cur) begin
               nxt    = cur;
               nxt_cf = 1'b1;
            end else begin
               nxt    = cur + ONE;
               nxt_cf = 1'b0;
            end
`else
            nxt    = inc_sum[WIDTH-1:0];
            nxt_cf = inc_sum[WIDTH];
`endif
         end
         OP_DEC: begin
`ifdef UNIV_REG_SAT_EN
            if (cur == '0) begin
               nxt    = '0;
               nxt_cf = 1'b1;
            end else begin
               nxt    = cur - ONE;
               nxt_cf = 1'b0;
            end
`else
            nxt    = cur - ONE;
            nxt_cf = (cur == '0);
`endif
         end
         OP_SHL: begin
            nxt    = {cur[WIDTH-2:0], sin};
            nxt_cf = cur[WIDTH-1];
         end
         OP_SHR: begin
            nxt    = {sin, cur[WIDTH-1:1]};
            nxt_cf = cur[0];
         end
         OP_ROL: begin
            nxt    = {cur[WIDTH-2:0], cur[WIDTH-1]};
            nxt_cf = cur[WIDTH-1];
         end
         OP_CLR: begin
            nxt    = '0;
            nxt_cf = 1'b0;
         end
         default: begin
            nxt    = cur;
            nxt_cf = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/univ_reg.sv
// -----------------------------------------------------------------------------
// univ_reg
// Parametrised universal register: hold, load, increment, decrement, shift
// left/right, rotate left and clear, with a registered carry/borrow/shift-out
// flag and a zero flag.
// Configuration macro: UNIV_REG_SAT_EN (saturating INC/DEC, see univ_reg_alu).
// Parameters:
//   WIDTH   register width (>= 2)
//   RST_VAL value of out while reset is asserted
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      asynchronous active-low reset
//   en     in   1      operation enable; low forces hold
//   op     in   3      operation select (univ_reg_pkg::op_e)
//   in     in   WIDTH  parallel load data
//   sin    in   1      serial input for SHL/SHR
//   out    out  WIDTH  register contents
//   cf     out  1      registered carry/borrow/shift-out flag
//   zf     out  1      out == 0, derived from the register only
// -----------------------------------------------------------------------------
module univ_reg
   import univ_reg_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [UNIV_REG_OP_W-1:0] op,
   input  logic [WIDTH-1:0]         in,
   input  logic                     sin,
   output logic [WIDTH-1:0]         out,
   output logic                     cf,
   output logic                     zf
);

   logic [WIDTH-1:0] nxt;
   logic             nxt_cf;
   logic             take;

   univ_reg_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .cur    (out),
      .in     (in),
      .sin    (sin),
      .op     (op),
      .nxt    (nxt),
      .nxt_cf (nxt_cf)
   );

   // NOP and en=0 both leave out and cf untouched, which keeps cf sticky
   // until the next real operation.
   assign take = en && (op != OP_NOP);

   // Register and flag; reset wins over any operation on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out <= RST_VAL;
         cf  <= 1'b0;
      end else if (take) begin
         out <= nxt;
         cf  <= nxt_cf;
      end
   end

   assign zf = (out == '0);

endmodule

// File: tb/tb_univ_reg.sv
// -----------------------------------------------------------------------------
// tb_univ_reg
// Self-checking bench for univ_reg (WIDTH=8, RST_VAL=8'hA5). Each operation
// driven pushes the model's expected {cf,out} into a scoreboard queue; the
// test task pops it once the DUT has taken the edge and compares out/cf/zf.
// -----------------------------------------------------------------------------
module tb_univ_reg;
   import univ_reg_pkg::*;

   localparam logic [7:0] RST_VAL = 8'hA5;

   typedef struct {
      logic       e;
      logic [2:0] o;
      logic [7:0] d;
      logic       s;
   } step_t;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [2:0] op;
   logic [7:0] in;
   logic       sin;
   logic [7:0] out;
   logic       cf;
   logic       zf;

   int checks;
   int errors;

   logic [7:0] mdl_out;
   logic       mdl_cf;
   logic [8:0] sb[$];

   univ_reg #(
      .WIDTH   (8),
      .RST_VAL (RST_VAL)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .op    (op),
      .in    (in),
      .sin   (sin),
      .out   (out),
      .cf    (cf),
      .zf    (zf)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference behaviour of one clock edge, returns {cf, out}.
   function automatic logic [8:0] model_step(logic [7:0] cur, logic c, step_t st);
      if (!st.e || st.o == 3'd0) return {c, cur};
      case (st.o)
         3'd1: return {1'b0, st.d};
`ifdef UNIV_REG_SAT_EN
         3'd2: return (cur == 8'hFF) ? {1'b1, 8'hFF} : {1'b0, cur + 8'd1};
         3'd3: return (cur == 8'h00) ? {1'b1, 8'h00} : {1'b0, cur - 8'd1};
`else
         3'd2: return {1'b0, cur} + 9'd1;
         3'd3: return {(cur == 8'h00), cur - 8'd1};
`endif
         3'd4: return {cur[7], cur[6:0], st.s};
         3'd5: return {cur[0], st.s, cur[7:1]};
         3'd6: return {cur[7], cur[6:0], cur[7]};
         default: return 9'd0;
      endcase
   endfunction

   // Drive one operation, record the expected result, let the edge happen
   // and return 1 ns after it.
   task automatic applyStimulus(input step_t st);
      logic [8:0] nx;
      en  = st.e;
      op  = st.o;
      in  = st.d;
      sin = st.s;
      nx = model_step(mdl_out, mdl_cf, st);
      mdl_out = nx[7:0];
      mdl_cf  = nx[8];
      sb.push_back(nx);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      mdl_out = RST_VAL;
      mdl_cf  = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      step_t seq[1] = '{'{1'b1, OP_LD, 8'h3C, 1'b0}};
      logic [8:0] exp;
      applyStimulus(seq[0]);
      exp = sb.pop_front();
      checks++;
      if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL reset_preload out got %h expected %h", out, exp[7:0]); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks += 3;
      if (out !== RST_VAL) begin errors++; $display("[TB] FAIL reset_async out got %h expected %h", out, RST_VAL); end
      if (cf !== 1'b0) begin errors++; $display("[TB] FAIL reset_async cf got %b expected 0", cf); end
      if (zf !== 1'b0) begin errors++; $display("[TB] FAIL reset_async zf got %b expected 0", zf); end
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_inc_wrap();
      step_t seq[3] = '{'{1'b1, OP_LD, 8'hFE, 1'b0}, '{1'b1, OP_INC, 8'h00, 1'b0}, '{1'b1, OP_INC, 8'h00, 1'b0}};
      logic [8:0] exp;
      foreach (seq[i]) begin
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         checks += 3;
         if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL inc_wrap[%0d] out got %h expected %h", i, out, exp[7:0]); end
         if (cf !== exp[8]) begin errors++; $display("[TB] FAIL inc_wrap[%0d] cf got %b expected %b", i, cf, exp[8]); end
         if (zf !== (exp[7:0] == 8'h00)) begin errors++; $display("[TB] FAIL inc_wrap[%0d] zf got %b expected %b", i, zf, exp[7:0] == 8'h00); end
      end
   endtask

   task automatic test_dec_borrow();
      step_t seq[3] = '{'{1'b1, OP_LD, 8'h00, 1'b0}, '{1'b1, OP_DEC, 8'h00, 1'b0}, '{1'b1, OP_DEC, 8'h00, 1'b0}};
      logic [8:0] exp;
      foreach (seq[i]) begin
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         checks += 3;
         if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL dec_borrow[%0d] out got %h expected %h", i, out, exp[7:0]); end
         if (cf !== exp[8]) begin errors++; $display("[TB] FAIL dec_borrow[%0d] cf got %b expected %b", i, cf, exp[8]); end
         if (zf !== (exp[7:0] == 8'h00)) begin errors++; $display("[TB] FAIL dec_borrow[%0d] zf got %b expected %b", i, zf, exp[7:0] == 8'h00); end
      end
   endtask

   task automatic test_shifts();
      step_t seq[5] = '{'{1'b1, OP_LD, 8'b1000_0001, 1'b0}, '{1'b1, OP_SHL, 8'h00, 1'b0},
                        '{1'b1, OP_SHR, 8'h00, 1'b1}, '{1'b1, OP_ROL, 8'h00, 1'b0},
                        '{1'b1, OP_CLR, 8'hFF, 1'b1}};
      logic [8:0] exp;
      foreach (seq[i]) begin
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         checks += 3;
         if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL shifts[%0d] out got %b expected %b", i, out, exp[7:0]); end
         if (cf !== exp[8]) begin errors++; $display("[TB] FAIL shifts[%0d] cf got %b expected %b", i, cf, exp[8]); end
         if (zf !== (exp[7:0] == 8'h00)) begin errors++; $display("[TB] FAIL shifts[%0d] zf got %b expected %b", i, zf, exp[7:0] == 8'h00); end
      end
   endtask

   task automatic test_enable_hold();
      // The SHL leaves cf=1 so holding it is distinguishable from clearing it.
      step_t seq[6] = '{'{1'b1, OP_LD, 8'hBC, 1'b0}, '{1'b1, OP_SHL, 8'h00, 1'b0},
                        '{1'b0, OP_INC, 8'h00, 1'b0}, '{1'b0, OP_INC, 8'h11, 1'b1},
                        '{1'b0, OP_INC, 8'h22, 1'b0}, '{1'b1, OP_NOP, 8'h33, 1'b1}};
      logic [8:0] exp;
      foreach (seq[i]) begin
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         checks += 3;
         if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL enable_hold[%0d] out got %h expected %h", i, out, exp[7:0]); end
         if (cf !== exp[8]) begin errors++; $display("[TB] FAIL enable_hold[%0d] cf got %b expected %b", i, cf, exp[8]); end
         if (zf !== (exp[7:0] == 8'h00)) begin errors++; $display("[TB] FAIL enable_hold[%0d] zf got %b expected %b", i, zf, exp[7:0] == 8'h00); end
      end
   endtask

   task automatic test_reset_mid_op();
      step_t seq[3] = '{'{1'b1, OP_LD, 8'h10, 1'b0}, '{1'b1, OP_INC, 8'h00, 1'b0}, '{1'b1, OP_INC, 8'h00, 1'b0}};
      step_t inc = '{1'b1, OP_INC, 8'h00, 1'b0};
      logic [8:0] exp;
      foreach (seq[i]) begin
         applyStimulus(seq[i]);
         exp = sb.pop_front();
         checks++;
         if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL mid_reset_pre[%0d] out got %h expected %h", i, out, exp[7:0]); end
      end
      // INC still presented while reset asserts and across an edge.
      en = 1'b1;
      op = OP_INC;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks += 2;
      if (out !== RST_VAL) begin errors++; $display("[TB] FAIL mid_reset_async out got %h expected %h", out, RST_VAL); end
      if (cf !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_async cf got %b expected 0", cf); end
      @(posedge clk);
      #1;
      checks++;
      if (out !== RST_VAL) begin errors++; $display("[TB] FAIL mid_reset_held out got %h expected %h", out, RST_VAL); end
      #2;
      rst_n = 1'b1;
      applyStimulus(inc);
      exp = sb.pop_front();
      checks += 2;
      if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL mid_reset_release out got %h expected %h", out, exp[7:0]); end
      if (out !== 8'hA6) begin errors++; $display("[TB] FAIL mid_reset_first_inc out got %h expected a6", out); end
   endtask

   task automatic test_back_to_back();
      step_t st;
      logic [8:0] exp;
      for (int i = 0; i < 60; i++) begin
         st.e = ($urandom_range(0, 7) != 0);
         st.o = 3'($urandom_range(0, 7));
         st.d = 8'($urandom_range(0, 255));
         st.s = 1'($urandom_range(0, 1));
         applyStimulus(st);
         exp = sb.pop_front();
         checks += 3;
         if (out !== exp[7:0]) begin errors++; $display("[TB] FAIL b2b[%0d] op %0d out got %h expected %h", i, st.o, out, exp[7:0]); end
         if (cf !== exp[8]) begin errors++; $display("[TB] FAIL b2b[%0d] op %0d cf got %b expected %b", i, st.o, cf, exp[8]); end
         if (zf !== (exp[7:0] == 8'h00)) begin errors++; $display("[TB] FAIL b2b[%0d] zf got %b expected %b", i, zf, exp[7:0] == 8'h00); end
      end
   endtask

   // Power-up reset, then each scenario in turn.
   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      en     = 1'b0;
      op     = OP_NOP;
      in     = 8'h00;
      sin    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks += 3;
      if (out !== RST_VAL) begin errors++; $display("[TB] FAIL power_on out got %h expected %h", out, RST_VAL); end
      if (cf !== 1'b0) begin errors++; $display("[TB] FAIL power_on cf got %b expected 0", cf); end
      if (zf !== 1'b0) begin errors++; $display("[TB] FAIL power_on zf got %b expected 0", zf); end
      rst_n = 1'b1;

      test_reset();
      test_inc_wrap();
      test_dec_borrow();
      test_shifts();
      test_enable_hold();
      test_reset_mid_op();
      test_back_to_back();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
